// File: rtl/mux_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mux_bus_arbiter
//
// Four-requester round-robin arbiter that owns the select lines of a 4-way
// 16-bit mux tree and gates its output onto a shared 16-bit consumer. Only
// the current grant holder's word reaches `out`. A hold counter bounds how
// long one requester may keep the bus.
//
// Ports
//   clk    in   1   system clock, all state updates on the rising edge
//   reset  in   1   synchronous, active-high reset
//   req    in   4   level request lines, bit i = requester i
//   in_a   in  16   data word of requester 0
//   in_b   in  16   data word of requester 1
//   in_c   in  16   data word of requester 2
//   in_d   in  16   data word of requester 3
//   grant  out  4   registered one-hot grant, all-zero when idle
//   sel    out  2   registered mux select, index of the owner (kept when idle)
//   busy   out  1   registered, equals |grant
//   out    out 16   combinational: selected word while busy, else 16'h0000
//
// Handshake: req[i] is a level. The arbiter samples req only at the rising
// edge; a requester holds req[i] for as long as it wants the bus and sees
// ownership through grant[i]. Dropping req[i] while owning releases the bus
// at the next edge. Every ownership change passes through one grant=0 cycle.
//
// Parameters
//   MAX_HOLD  max consecutive owned cycles before forced revoke, 0 = no limit
//   CNT_W     hold counter width, MAX_HOLD must be below 2**CNT_W
//
// The FSM state is kept in the signal `state` (type state_t) so checkers can
// bind to it directly.
// ---------------------------------------------------------------------------

// Two-input 16-bit mux primitive: y = s ? b : a.
module mux16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        s,
   output logic [15:0] y
);
   assign y = s ? b : a;
endmodule

// Four-input 16-bit mux built from three mux16 primitives.
module mux4way16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [15:0] c,
   input  logic [15:0] d,
   input  logic [1:0]  s,
   output logic [15:0] y
);
   logic [15:0] ab;
   logic [15:0] cd;

   mux16 u_ab  (.a(a),  .b(b),  .s(s[0]), .y(ab));
   mux16 u_cd  (.a(c),  .b(d),  .s(s[0]), .y(cd));
   mux16 u_out (.a(ab), .b(cd), .s(s[1]), .y(y));
endmodule

module mux_bus_arbiter #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  req,
   input  logic [15:0] in_a,
   input  logic [15:0] in_b,
   input  logic [15:0] in_c,
   input  logic [15:0] in_d,
   output logic [3:0]  grant,
   output logic [1:0]  sel,
   output logic        busy,
   output logic [15:0] out
);

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   localparam bit               HOLD_EN   = (MAX_HOLD != 0);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t           state;
   logic [1:0]       ptr;
   logic [CNT_W-1:0] count;

   logic [1:0]       winner;
   logic             found;
   logic [1:0]       idx;
   logic             release_now;
   logic [15:0]      mux_y;

   // Round-robin scan: ptr+1, ptr+2, ptr+3, then ptr itself, so the last
   // owner has the lowest priority in the next arbitration.
   always_comb begin
      winner = ptr;
      found  = 1'b0;
      idx    = ptr;
      for (int k = 1; k <= 4; k++) begin
         idx = ptr + 2'(k);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   // The owner leaves at the next edge if it stopped requesting or it has
   // used up its hold budget (count runs 0..MAX_HOLD-1 while owning).
   assign release_now = !req[sel] || (HOLD_EN && (count == HOLD_LAST));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         grant <= 4'b0000;
         sel   <= 2'd0;
         busy  <= 1'b0;
         ptr   <= 2'd3;
         count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  grant <= 4'b0001 << winner;
                  sel   <= winner;
                  busy  <= 1'b1;
                  ptr   <= winner;
                  count <= '0;
                  state <= OWN;
               end
            end
            OWN: begin
               // Non-owner requests are deliberately not looked at here;
               // they compete at the next IDLE cycle. sel keeps the owner.
               if (release_now) begin
                  grant <= 4'b0000;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (count != CNT_MAX) begin
                  count <= count + CNT_W'(1);
               end
            end
         endcase
      end
   end

   mux4way16 u_mux (
      .a (in_a),
      .b (in_b),
      .c (in_c),
      .d (in_d),
      .s (sel),
      .y (mux_y)
   );

   // sel keeps the last owner while idle, so the output must be gated.
   assign out = busy ? mux_y : 16'h0000;

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_bus_arbiter
//
// Directed bench for mux_bus_arbiter. Two instances share the stimulus:
// dut4 (MAX_HOLD=4) for the rotation sequence and dut16 (MAX_HOLD=16) for
// everything else. Inputs are driven and outputs sampled 1 time unit after
// each rising edge.
// ---------------------------------------------------------------------------
module tb_mux_bus_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req;
   logic [15:0] in_a, in_b, in_c, in_d;

   logic [3:0]  g4,  g16;
   logic [1:0]  s4,  s16;
   logic        b4,  b16;
   logic [15:0] o4,  o16;

   int n_checks;
   int n_fail;

   mux_bus_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut4 (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .in_a  (in_a),
      .in_b  (in_b),
      .in_c  (in_c),
      .in_d  (in_d),
      .grant (g4),
      .sel   (s4),
      .busy  (b4),
      .out   (o4)
   );

   mux_bus_arbiter #(.MAX_HOLD(16), .CNT_W(8)) dut16 (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .in_a  (in_a),
      .in_b  (in_b),
      .in_c  (in_c),
      .in_d  (in_d),
      .grant (g16),
      .sel   (s16),
      .busy  (b16),
      .out   (o16)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Full output check of the MAX_HOLD=16 instance.
   task automatic chk16(input string tag, input logic [3:0] eg, input logic [1:0] es,
                        input logic eb, input logic [15:0] eo);
      chk({tag, ".grant"}, 16'(g16), 16'(eg));
      chk({tag, ".sel"},   16'(s16), 16'(es));
      chk({tag, ".busy"},  16'(b16), 16'(eb));
      chk({tag, ".out"},   o16,      eo);
   endtask

   // Full output check of the MAX_HOLD=4 instance.
   task automatic chk4(input string tag, input logic [3:0] eg, input logic [1:0] es,
                       input logic eb, input logic [15:0] eo);
      chk({tag, ".grant"}, 16'(g4), 16'(eg));
      chk({tag, ".sel"},   16'(s4), 16'(es));
      chk({tag, ".busy"},  16'(b4), 16'(eb));
      chk({tag, ".out"},   o4,      eo);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = 4'b0000;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      req      = 4'b0000;
      in_a     = 16'h000A;
      in_b     = 16'h000B;
      in_c     = 16'h000C;
      in_d     = 16'h000D;

      // 1) reset, then five idle cycles with no requests
      do_reset();
      chk16("rst", 4'b0000, 2'd0, 1'b0, 16'h0000);
      chk4 ("rst4", 4'b0000, 2'd0, 1'b0, 16'h0000);
      for (int t = 0; t < 5; t++) begin
         tick();
         chk16($sformatf("idle%0d", t), 4'b0000, 2'd0, 1'b0, 16'h0000);
      end

      // 2) all four request, MAX_HOLD=4: 0,1,2,3,0 for 4 cycles each,
      //    one grant=0 cycle between owners
      do_reset();
      req = 4'b1111;
      for (int o = 0; o < 5; o++) begin
         for (int c = 0; c < 4; c++) begin
            tick();
            chk4($sformatf("rr.o%0d.c%0d", o, c), 4'b0001 << (o % 4), 2'(o % 4),
                 1'b1, 16'h000A + 16'(o % 4));
         end
         if (o < 4) begin
            tick();
            chk4($sformatf("rr.bubble%0d", o), 4'b0000, 2'(o % 4), 1'b0, 16'h0000);
         end
      end

      // 3) only requester 2, MAX_HOLD=16, 40 cycles: 16 owned, 1 bubble, ...
      do_reset();
      req = 4'b0100;
      for (int t = 1; t <= 40; t++) begin
         tick();
         if (((t - 1) % 17) < 16)
            chk16($sformatf("solo.t%0d", t), 4'b0100, 2'd2, 1'b1, 16'h000C);
         else
            chk16($sformatf("solo.t%0d", t), 4'b0000, 2'd2, 1'b0, 16'h0000);
      end

      // 4) owner 1 releases after 3 cycles, requester 3 pending
      do_reset();
      req = 4'b1010;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk16($sformatf("drop.own%0d", c), 4'b0010, 2'd1, 1'b1, 16'h000B);
      end
      req = 4'b1000;
      tick();
      chk16("drop.bubble", 4'b0000, 2'd1, 1'b0, 16'h0000);
      tick();
      chk16("drop.next", 4'b1000, 2'd3, 1'b1, 16'h000D);

      // 5) req=1001 from reset: 0 first, then 3 ahead of 0
      do_reset();
      req = 4'b1001;
      tick();
      chk16("prio.first", 4'b0001, 2'd0, 1'b1, 16'h000A);
      tick();
      chk16("prio.hold", 4'b0001, 2'd0, 1'b1, 16'h000A);
      req = 4'b1000;
      tick();
      chk16("prio.rel0", 4'b0000, 2'd0, 1'b0, 16'h0000);
      req = 4'b1001;
      tick();
      chk16("prio.win3", 4'b1000, 2'd3, 1'b1, 16'h000D);
      req = 4'b0001;
      tick();
      chk16("prio.rel3", 4'b0000, 2'd3, 1'b0, 16'h0000);
      tick();
      chk16("prio.back0", 4'b0001, 2'd0, 1'b1, 16'h000A);

      // 6) reset during cycle 2 of a grant to requester 2
      do_reset();
      req = 4'b0100;
      tick();
      chk16("rstmid.c1", 4'b0100, 2'd2, 1'b1, 16'h000C);
      tick();
      chk16("rstmid.c2", 4'b0100, 2'd2, 1'b1, 16'h000C);
      reset = 1'b1;
      req   = 4'b0110;
      tick();
      chk16("rstmid.rst", 4'b0000, 2'd0, 1'b0, 16'h0000);
      reset = 1'b0;
      tick();
      chk16("rstmid.win1", 4'b0010, 2'd1, 1'b1, 16'h000B);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
